// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit state encoding
package uart_pkg;

  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS     = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - 8N1/8N2 UART transmitter with one-entry holding register
// Optional parity cell after data bit 7 when UART_TX_PARITY_EN is defined.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_x16_tick,
  input  logic       tx_in_valid,
  output logic       tx_in_ready,
  input  logic [7:0] tx_in_data,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_frame_done
);

  if ((STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_tx_engine: STOP_BITS must be 1 or 2 and PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t state, state_nxt;
  logic [3:0] tick_counter;
  logic [2:0] bit_index, bit_index_nxt;
  logic       stop_index, stop_index_nxt;
  logic       hold_valid;
  logic [7:0] hold_data;
  logic [7:0] shift_reg, shift_nxt;
  logic       load;
  logic       frame_end;
  logic       tx_nxt;
  logic       bit_end;

  assign bit_end     = baud_x16_tick && (tick_counter == 4'(TICKS_PER_BIT - 1));
  assign tx_in_ready = !hold_valid;
  assign tx_busy     = (state != S_IDLE);

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^shift_reg) ^ PARITY_ODD[0];
`endif

  always_comb begin
    state_nxt      = state;
    bit_index_nxt  = bit_index;
    stop_index_nxt = stop_index;
    shift_nxt      = shift_reg;
    load           = 1'b0;
    frame_end      = 1'b0;
    case (state)
      S_IDLE: begin
        // Leaving idle only on a tick keeps the start cell exactly 16 ticks long.
        if (baud_x16_tick && hold_valid) begin
          state_nxt = S_START;
          load      = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt     = S_DATA;
          bit_index_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_index_nxt = bit_index + 3'd1;
          if (bit_index == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
            stop_index_nxt = 1'b0;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_nxt      = S_STOP;
          stop_index_nxt = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_index == 1'(STOP_BITS - 1)) begin
            frame_end = 1'b1;
            if (hold_valid) begin
              state_nxt = S_START;
              load      = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            stop_index_nxt = stop_index + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (load) shift_nxt = hold_data;

    // Line level follows the next state so it switches on the same edge as the FSM.
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[bit_index_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_nxt = parity_bit;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tick_counter  <= 4'd0;
      bit_index     <= 3'd0;
      stop_index    <= 1'b0;
      hold_valid    <= 1'b0;
      hold_data     <= 8'h00;
      shift_reg     <= 8'h00;
      uart_tx       <= 1'b1;
      tx_frame_done <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_index     <= bit_index_nxt;
      stop_index    <= stop_index_nxt;
      shift_reg     <= shift_nxt;
      uart_tx       <= tx_nxt;
      tx_frame_done <= frame_end;

      if (load) begin
        tick_counter <= 4'd0;
      end else if (baud_x16_tick) begin
        tick_counter <= tick_counter + 4'd1;
      end

      if (load) begin
        hold_valid <= 1'b0;
      end else if (tx_in_valid && tx_in_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_in_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine (STOP_BITS 1 and 2, optional UART_TX_PARITY_EN)
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PODD = 0;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       rdy  [2];
  logic       line [2];
  logic       busy [2];
  logic       done [2];

  uart_tx_engine #(.STOP_BITS(1), .PARITY_ODD(PODD)) u_sb1 (
    .clk(clk), .rst(rst), .baud_x16_tick(tick), .tx_in_valid(valid), .tx_in_ready(rdy[0]),
    .tx_in_data(data), .uart_tx(line[0]), .tx_busy(busy[0]), .tx_frame_done(done[0])
  );

  uart_tx_engine #(.STOP_BITS(2), .PARITY_ODD(PODD)) u_sb2 (
    .clk(clk), .rst(rst), .baud_x16_tick(tick), .tx_in_valid(valid), .tx_in_ready(rdy[1]),
    .tx_in_data(data), .uart_tx(line[1]), .tx_busy(busy[1]), .tx_frame_done(done[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endfunction

  // Reference: a frame is a list of line levels, one entry per tick period.
  bit         fq   [2][$];
  logic [7:0] pend [2][$];
  logic       m_line [2];
  logic       m_busy [2];
  logic       m_done [2];
  logic       m_rdy  [2];
  logic       acc_m  [2];
  logic       edge_tick = 1'b0;
  logic       edge_rst  = 1'b0;

  function automatic void push_frame(input int d, input logic [7:0] b);
    bit cells[$];
    cells.push_back(1'b0);
    for (int i = 0; i < 8; i++) cells.push_back(b[i]);
    if (PAR == 1) cells.push_back(bit'(($countones(b) + PODD) % 2));
    for (int i = 0; i <= d; i++) cells.push_back(1'b1);
    for (int k = 0; k < cells.size(); k++)
      for (int t = 0; t < 16; t++) fq[d].push_back(cells[k]);
  endfunction

  always @(posedge clk) begin
    edge_tick = tick;
    edge_rst  = rst;
    for (int d = 0; d < 2; d++) begin
      acc_m[d]  = valid && (pend[d].size() == 0);
      m_done[d] = 1'b0;
      if (rst) begin
        fq[d].delete();
        pend[d].delete();
      end else begin
        if (tick) begin
          if (fq[d].size() > 0) begin
            void'(fq[d].pop_front());
            if (fq[d].size() == 0) begin
              m_done[d] = 1'b1;
              if (pend[d].size() > 0) push_frame(d, pend[d].pop_front());
            end
          end else if (pend[d].size() > 0) begin
            push_frame(d, pend[d].pop_front());
          end
        end
        if (acc_m[d]) pend[d].push_back(data);
      end
      m_busy[d] = (fq[d].size() > 0);
      m_line[d] = (fq[d].size() > 0) ? fq[d][0] : 1'b1;
      m_rdy[d]  = (pend[d].size() == 0);
    end
  end

  // Per-cycle comparison plus a per-tick recording of each emitted frame.
  bit rec        [2][$];
  bit last_frame [2][$];
  int frames     [2];

  initial begin
    frames[0] = 0;
    frames[1] = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("uart_tx", d, 32'(line[d]), 32'(m_line[d]));
      chk("tx_busy", d, 32'(busy[d]), 32'(m_busy[d]));
      chk("tx_frame_done", d, 32'(done[d]), 32'(m_done[d]));
      chk("tx_in_ready", d, 32'(rdy[d]), 32'(m_rdy[d]));
      if (edge_rst) begin
        rec[d].delete();
      end else if (edge_tick) begin
        if (done[d]) begin
          last_frame[d].delete();
          for (int t = 0; t < rec[d].size(); t++) last_frame[d].push_back(rec[d][t]);
          frames[d]++;
          rec[d].delete();
        end
        if (busy[d]) rec[d].push_back(line[d]);
      end
    end
  end

  int cyc = 0;
  int tick_mode = 0;

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
    case (tick_mode)
      0:       tick = (cyc % 4 == 0);
      1:       tick = ($urandom_range(0, 2) == 0);
      default: tick = 1'b0;
    endcase
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy[0] || busy[1] || !rdy[0] || !rdy[1]) && n < budget) begin
      step();
      n++;
    end
    chk("idle_reached", 0, 32'(!(busy[0] || busy[1] || !rdy[0] || !rdy[1])), 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input int budget);
    int   n   = 0;
    logic acc = 1'b0;
    data  = b;
    valid = 1'b1;
    while (!acc && n < budget) begin
      acc = rdy[0];
      step();
      n++;
    end
    chk("accept", 0, 32'(acc), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] cells;
    logic       even_par;
  } vec_t;

  vec_t vt[6];
  int   f0, f1, n, ncell;
  logic seen0, seen1, ok, expv;

  initial begin
    vt[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vt[1] = '{8'h00, 10'b1000000000, 1'b0};
    vt[2] = '{8'h07, 10'b1000001110, 1'b1};
    vt[3] = '{8'hFF, 10'b1111111110, 1'b0};
    vt[4] = '{8'h80, 10'b1100000000, 1'b1};
    vt[5] = '{8'h55, 10'b1010101010, 1'b0};

    rst = 1'b1;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_uart_tx", d, 32'(line[d]), 32'd1);
      chk("reset_busy", d, 32'(busy[d]), 32'd0);
      chk("reset_done", d, 32'(done[d]), 32'd0);
      chk("reset_ready", d, 32'(rdy[d]), 32'd1);
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wait_idle(4000);
      f0 = frames[0];
      f1 = frames[1];
      send(vt[i].data, 20);
      valid = 1'b0;
      seen0 = 1'b0;
      seen1 = 1'b0;
      n = 0;
      while (!(seen0 && seen1) && n < 3000) begin
        step();
        n++;
        if (done[0]) begin seen0 = 1'b1; chk("busy_low_at_done", 0, 32'(busy[0]), 32'd0); end
        if (done[1]) begin seen1 = 1'b1; chk("busy_low_at_done", 1, 32'(busy[1]), 32'd0); end
      end
      chk("frame_done_seen", 0, 32'(seen0 && seen1), 32'd1);
      repeat (20) step();
      chk("done_pulses", 0, 32'(frames[0] - f0), 32'd1);
      chk("done_pulses", 1, 32'(frames[1] - f1), 32'd1);
      for (int d = 0; d < 2; d++) begin
        ncell = 10 + PAR + d;
        chk($sformatf("vec%0d_frame_ticks", i), d, 32'(last_frame[d].size()), 32'(16 * ncell));
        if (last_frame[d].size() == 16 * ncell) begin
          for (int k = 0; k < ncell; k++) begin
            if (k < 9) expv = vt[i].cells[k];
            else if (PAR == 1 && k == 9) expv = vt[i].even_par ^ 1'(PODD);
            else expv = 1'b1;
            ok = 1'b1;
            for (int t = 0; t < 16; t++) if (last_frame[d][16 * k + t] !== expv) ok = 1'b0;
            chk($sformatf("vec%0d_cell%0d", i, k), d, 32'(ok), 32'd1);
          end
        end
      end
    end

    // Back-to-back: second start cell begins on the edge that ends the first stop cell.
    wait_idle(4000);
    send(8'h55, 20);
    send(8'h0F, 40);
    valid = 1'b0;
    n = 0;
    while (!done[0] && n < 3000) begin step(); n++; end
    chk("b2b_done_seen", 0, 32'(done[0]), 32'd1);
    chk("b2b_busy_kept", 0, 32'(busy[0]), 32'd1);
    chk("b2b_start_low", 0, 32'(line[0]), 32'd0);
    chk("b2b_ready_after_load", 0, 32'(rdy[0]), 32'd1);

    // Backpressure: valid held high across three queued bytes.
    wait_idle(4000);
    f0 = frames[0];
    send(8'h3A, 20);
    send(8'hC5, 40);
    chk("bp_frames_after_two", 0, 32'(frames[0] - f0), 32'd0);
    send(8'h81, 4000);
    chk("bp_frames_after_three", 0, 32'(frames[0] - f0), 32'd1);
    valid = 1'b0;
    wait_idle(6000);
    chk("bp_total_frames", 0, 32'(frames[0] - f0), 32'd3);

    // Reset in data bit 3 with a second byte held.
    wait_idle(4000);
    send(8'h3C, 20);
    send(8'hC3, 40);
    valid = 1'b0;
    n = 0;
    while (rec[0].size() < 72 && n < 2000) begin step(); n++; end
    chk("reached_bit3", 0, 32'(rec[0].size()), 32'd72);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_uart_tx", d, 32'(line[d]), 32'd1);
      chk("rst_mid_ready", d, 32'(rdy[d]), 32'd1);
      chk("rst_mid_busy", d, 32'(busy[d]), 32'd0);
    end
    f0 = frames[0];
    f1 = frames[1];
    repeat (1500) step();
    chk("no_frame_after_rst", 0, 32'(frames[0] - f0), 32'd0);
    chk("no_frame_after_rst", 1, 32'(frames[1] - f1), 32'd0);

    // No ticks: everything frozen mid-frame.
    send(8'h96, 20);
    valid = 1'b0;
    n = 0;
    while (rec[0].size() < 40 && n < 1000) begin step(); n++; end
    tick_mode = 2;
    tick = 1'b0;
    repeat (200) step();
    chk("frozen_ticks", 0, 32'(rec[0].size()), 32'd40);
    tick_mode = 0;
    wait_idle(4000);

    // Random ticks, valid, data and rare resets against the reference model.
    tick_mode = 1;
    for (int i = 0; i < 15000; i++) begin
      step();
      valid = ($urandom_range(0, 1) == 1);
      data  = 8'($urandom);
      rst   = ($urandom_range(0, 2999) == 0);
    end
    rst   = 1'b0;
    valid = 1'b0;
    wait_idle(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
